// File: rtl/mem_store_unit_pkg.sv
// Shared store-size encodings and size helper for the store unit.
package mem_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_WORD  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_BYTE  = 2'b10,
    SZ_DWORD = 2'b11
  } store_size_e;

  // Number of bytes written by a store of the given size encoding.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      SZ_WORD:  n = 4'd4;
      SZ_HALF:  n = 4'd2;
      SZ_BYTE:  n = 4'd1;
      default:  n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_store_unit_lane_encoder.sv
// Combinational lane encoder: positions right-justified store data into its
// byte lanes and produces the matching byte enables. Illegal sizes (dword on a
// 32-bit datapath) are folded into the misaligned flag so the top has a single
// reject condition.
module store_lane_encoder
  import mem_store_unit_pkg::*;
#(
  parameter int DW         = 32,
  parameter int BIG_ENDIAN = 1,
  localparam int NB        = DW / 8,
  localparam int OW        = $clog2(NB)
) (
  input  logic [OW-1:0] ofs,
  input  logic [1:0]    size,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] wdata,
  output logic [NB-1:0] be,
  output logic          misaligned
);

  int              nb;
  int              ofs_i;
  logic [DW-1:0]   size_mask;
  logic [NB-1:0]   size_be;

  // Shift the masked payload into place; big-endian left-justifies first so
  // the most significant store byte lands on the lowest byte offset.
  always_comb begin
    nb         = int'(size_bytes(size));
    ofs_i      = int'(ofs);
    misaligned = ((size == SZ_DWORD) && (DW != 64)) || ((ofs_i & (nb - 1)) != 0);
    size_mask  = {DW{1'b1}} >> (DW - 8 * nb);
    size_be    = {NB{1'b1}} >> (NB - nb);
    wdata      = '0;
    be         = '0;
    if (!misaligned) begin
      be = size_be << ofs_i;
      if (BIG_ENDIAN != 0) begin
        wdata = ((data & size_mask) << (DW - 8 * nb)) >> (8 * ofs_i);
      end else begin
        wdata = (data & size_mask) << (8 * ofs_i);
      end
    end
  end

endmodule

// File: rtl/mem_store_unit.sv
// Store buffer: accepts byte/half/word/dword stores, rejects misaligned ones,
// queues aligned ones in a FIFO and optionally combines a store into the
// youngest (non-head) entry when it targets the same aligned address.
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int DEPTH      = 4,
  parameter int BIG_ENDIAN = 1,
  parameter int MERGE      = 1,
  localparam int NB        = DW / 8,
  localparam int OW        = $clog2(NB),
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  input  logic [1:0]    req_size,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [NB-1:0] mem_be,
  output logic          err_valid,
  output logic [AW-1:0] err_addr,
  output logic [CW-1:0] count
);

  logic [AW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [NB-1:0] ent_be   [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] youngest;

  logic [AW-1:0] req_aligned;
  logic [DW-1:0] enc_wdata;
  logic [NB-1:0] enc_be;
  logic          enc_misaligned;
  logic [DW-1:0] merge_mask;

  logic          merge_hit;
  logic          accept;
  logic          do_push;
  logic          do_merge;
  logic          do_pop;

  store_lane_encoder #(
    .DW         (DW),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_enc (
    .ofs        (req_addr[OW-1:0]),
    .size       (req_size),
    .data       (req_data),
    .wdata      (enc_wdata),
    .be         (enc_be),
    .misaligned (enc_misaligned)
  );

  // Expand byte enables to a bit mask in the same lane order as the data.
  for (genvar k = 0; k < NB; k++) begin : g_mask
    localparam int LANE = (BIG_ENDIAN != 0) ? (DW - 8 - 8 * k) : (8 * k);
    assign merge_mask[LANE +: 8] = {8{enc_be[k]}};
  end

  assign req_aligned = {req_addr[AW-1:OW], {OW{1'b0}}};
  assign youngest    = wr_ptr - 1'b1;

  // With count>=2 the youngest entry is never the head, so a merge can never
  // disturb the beat currently offered to memory.
  assign merge_hit = (MERGE != 0) && (count >= CW'(2)) && !enc_misaligned &&
                     (req_aligned == ent_addr[youngest]);

  assign req_ready = (count < CW'(DEPTH)) || merge_hit;
  assign accept    = req_valid && req_ready;
  assign do_merge  = accept && merge_hit;
  assign do_push   = accept && !merge_hit && !enc_misaligned;
  assign do_pop    = mem_valid && mem_ready;

  assign mem_valid = (count != '0);
  assign mem_addr  = ent_addr[rd_ptr];
  assign mem_wdata = ent_data[rd_ptr];
  assign mem_be    = ent_be[rd_ptr];

  // FIFO storage, pointers and occupancy; push, merge and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_be[i]   <= '0;
      end
    end else begin
      if (do_push) begin
        ent_addr[wr_ptr] <= req_aligned;
        ent_data[wr_ptr] <= enc_wdata;
        ent_be[wr_ptr]   <= enc_be;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_merge) begin
        ent_data[youngest] <= (ent_data[youngest] & ~merge_mask) | enc_wdata;
        ent_be[youngest]   <= ent_be[youngest] | enc_be;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Rejected stores raise a one-cycle pulse; the address is kept for software.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_valid <= accept && enc_misaligned;
      if (accept && enc_misaligned) begin
        err_addr <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Scoreboard bench for mem_store_unit (DW=32, DEPTH=4) with a second
// little-endian instance for lane-mapping checks.
module tb_mem_store_unit;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_ready;

  logic        req_ready, mem_valid, err_valid;
  logic [31:0] mem_addr, mem_wdata, err_addr;
  logic [3:0]  mem_be;
  logic [2:0]  count;

  logic        le_req_ready, le_mem_valid, le_err_valid;
  logic [31:0] le_mem_addr, le_mem_wdata, le_err_addr;
  logic [3:0]  le_mem_be;
  logic [2:0]  le_count;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_store_unit #(.DW(32), .AW(32), .DEPTH(4), .BIG_ENDIAN(1), .MERGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .err_valid(err_valid),
    .err_addr(err_addr), .count(count)
  );

  mem_store_unit #(.DW(32), .AW(32), .DEPTH(4), .BIG_ENDIAN(0), .MERGE(1)) dut_le (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(le_req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(le_mem_valid), .mem_ready(mem_ready), .mem_addr(le_mem_addr),
    .mem_wdata(le_mem_wdata), .mem_be(le_mem_be), .err_valid(le_err_valid),
    .err_addr(le_err_addr), .count(le_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Beat monitor: every accepted memory beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      if (sb.size() == 0) begin
        chk("beat_unexpected", mem_addr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_addr", mem_addr, e.addr);
        chk("beat_be", 32'(mem_be), 32'(e.be));
        chk("beat_wdata", mem_wdata, e.wd);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                       input bit push, input logic [3:0] ebe, input logic [31:0] ewd);
    int n;
    exp_t e;
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = sz;
    req_data  = d;
    if (push) begin
      e.addr = {a[31:2], 2'b00};
      e.be   = ebe;
      e.wd   = ewd;
      sb.push_back(e);
    end
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) chk("store_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    mem_ready = 1'b1;
    while (count != 3'd0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_count", 32'(count), 32'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    req_size = 2'b00; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // Half at offset 2: big-endian vs little-endian lane placement.
    store(32'h2002, 2'b01, 32'h1234, 1'b1, 4'hC, 32'h0000_1234);
    chk("be_h2_addr", mem_addr, 32'h2000);
    chk("be_h2_be", 32'(mem_be), 32'hC);
    chk("be_h2_wd", mem_wdata, 32'h0000_1234);
    chk("le_h2_be", 32'(le_mem_be), 32'hC);
    chk("le_h2_wd", le_mem_wdata, 32'h1234_0000);
    drain();

    // Byte at offset 1, visible one cycle after acceptance.
    store(32'h1001, 2'b10, 32'hAB, 1'b1, 4'h2, 32'h00AB_0000);
    chk("byte_valid", 32'(mem_valid), 32'd1);
    chk("byte_addr", mem_addr, 32'h1000);
    chk("byte_be", 32'(mem_be), 32'h2);
    chk("byte_wd", mem_wdata, 32'h00AB_0000);
    drain();

    // Half at offset 0, then offset 2 (count=1: no merge into the head).
    store(32'h2000, 2'b01, 32'h1234, 1'b1, 4'h3, 32'h1234_0000);
    chk("h0_be", 32'(mem_be), 32'h3);
    chk("h0_wd", mem_wdata, 32'h1234_0000);
    store(32'h2002, 2'b01, 32'h1234, 1'b1, 4'hC, 32'h0000_1234);
    chk("h0h2_count", 32'(count), 32'd2);
    drain();

    // Misaligned half and illegal dword are rejected.
    store(32'h2001, 2'b01, 32'h5678, 1'b0, 4'h0, 32'h0);
    chk("mis_err_valid", 32'(err_valid), 32'd1);
    chk("mis_err_addr", err_addr, 32'h2001);
    chk("mis_count", 32'(count), 32'd0);
    chk("mis_mem_valid", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    chk("mis_err_pulse", 32'(err_valid), 32'd0);
    chk("mis_err_hold", err_addr, 32'h2001);
    store(32'h4000, 2'b11, 32'h9999, 1'b0, 4'h0, 32'h0);
    chk("dw_err_valid", 32'(err_valid), 32'd1);
    chk("dw_err_addr", err_addr, 32'h4000);
    chk("dw_count", 32'(count), 32'd0);

    // Fill to DEPTH, fifth store stalls, then drain one beat per cycle.
    for (int i = 0; i < 4; i++) begin
      store(32'h5000 + 32'(4 * i), 2'b00, 32'hA000_0000 + 32'(i), 1'b1, 4'hF,
            32'hA000_0000 + 32'(i));
    end
    chk("full_count", 32'(count), 32'd4);
    req_valid = 1'b1; req_addr = 32'h5010; req_size = 2'b00; req_data = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("full_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_head", mem_addr, 32'h5000);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("drain_step", 32'(count), 32'(3 - i));
    end
    mem_ready = 1'b0;

    // Write combining into the youngest entry.
    store(32'h3000, 2'b00, 32'hDEAD_BEEF, 1'b1, 4'hF, 32'hDEAD_BEEF);
    store(32'h3004, 2'b10, 32'h11, 1'b0, 4'h0, 32'h0);
    store(32'h3005, 2'b10, 32'h22, 1'b1, 4'h3, 32'h1122_0000);
    chk("merge_count", 32'(count), 32'd2);
    drain();

    // Head is never merged.
    store(32'h7000, 2'b00, 32'hCAFE_F00D, 1'b1, 4'hF, 32'hCAFE_F00D);
    store(32'h7001, 2'b10, 32'hAB, 1'b1, 4'h2, 32'h00AB_0000);
    chk("nohead_count", 32'(count), 32'd2);
    drain();

    // Merge into youngest while the head pops in the same cycle.
    store(32'h6000, 2'b00, 32'h0A0B_0C0D, 1'b1, 4'hF, 32'h0A0B_0C0D);
    store(32'h6004, 2'b00, 32'h0102_0304, 1'b0, 4'h0, 32'h0);
    mem_ready = 1'b1;
    store(32'h6007, 2'b10, 32'h77, 1'b1, 4'hF, 32'h0102_0377);
    chk("mergepop_count", 32'(count), 32'd1);
    drain();

    // Reset mid-operation discards buffered stores.
    for (int i = 0; i < 3; i++) begin
      store(32'h9000 + 32'(4 * i), 2'b00, 32'h5555_0000 + 32'(i), 1'b0, 4'h0, 32'h0);
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    store(32'h8000, 2'b00, 32'h1357_9BDF, 1'b1, 4'hF, 32'h1357_9BDF);
    chk("post_rst_count", 32'(count), 32'd1);
    drain();
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_store_unit.md
MEM_STORE_UNIT -- requirements
Module: mem_store_unit

Interface
REQ-001 Parameter DW, default 32, meaning store data width in bits; legal values are 32 and 64.
REQ-002 Parameter AW, default 32, meaning byte-address width.
REQ-003 Parameter DEPTH, default 4, meaning store-buffer entries; it is a power of 2 and at least 2.
REQ-004 Parameter BIG_ENDIAN, default 1, meaning lane mapping: 1 puts byte offset k at data[DW-1-8k -: 8]; 0 puts it at data[8k +: 8].
REQ-005 Parameter MERGE, default 1, meaning 1 enables write combining into the youngest entry.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 req_valid  in  1  store request present.
REQ-009 req_ready  out  1  unit can accept a store.
REQ-010 req_addr  in  AW  byte address of the store.
REQ-011 req_data  in  DW  store data, right-justified (LSBs hold the byte, half or word).
REQ-012 req_size  in  2  store size: 00 word, 01 half, 10 byte, 11 dword (legal only when DW=64).
REQ-013 mem_valid  out  1  head entry presented to memory.
REQ-014 mem_ready  in  1  memory accepts the head entry.
REQ-015 mem_addr  out  AW  DW/8-aligned address of the head entry.
REQ-016 mem_wdata  out  DW  lane-positioned data of the head entry.
REQ-017 mem_be  out  DW/8  byte enables; bit k qualifies byte offset k.
REQ-018 err_valid  out  1  one-cycle pulse flagging a rejected store.
REQ-019 err_addr  out  AW  address of the rejected store; holds until the next error.
REQ-020 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-021 A store is accepted only on a cycle with req_valid=1 and req_ready=1.
REQ-022 req_ready SHALL equal (count<DEPTH), or a merge hit as defined in REQ-027; there is no combinational path from mem_ready to req_ready.
REQ-023 The store is aligned when addr mod size_bytes = 0; a misaligned store or illegal size is accepted, is not enqueued, and drives err_valid=1 with err_addr=req_addr in the next cycle.
REQ-024 For an aligned store, the encoder places size_bytes bytes of req_data at byte offsets ofs .. ofs+size_bytes-1, where ofs=addr mod (DW/8); mem_be sets those bits, and all other data bits are 0.
REQ-025 The buffer is FIFO; mem_valid=(count!=0); mem_addr, mem_wdata and mem_be come from registered head state with no combinational path from req_*.
REQ-026 Latency: a store accepted in cycle N is visible at the head no earlier than cycle N+1.
REQ-027 Merge hit: MERGE=1, count>=2, aligned request, and the aligned address equals the youngest entry's address; on a hit the new lanes overwrite that entry's data, be becomes OR(be), and count is unchanged.
REQ-028 The head entry is never merged, even when count=1.
REQ-029 Simultaneous push and pop: count is unchanged, and the pointers wrap modulo DEPTH.
REQ-030 Simultaneous merge and pop of a different (head) entry: both take effect.
REQ-031 A request that is not accepted while full SHALL leave all state unchanged.

Reset
REQ-032 While rst_n=0: count=0, pointers=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, err_valid=0, err_addr=0, and req_ready=1 after deassertion.
REQ-033 Reset asserted mid-operation discards all buffered stores without any mem_valid beat.

Structure
REQ-034 A shared package holds the req_size encodings (SZ_WORD, SZ_HALF, SZ_BYTE, SZ_DWORD) and a function returning size_bytes.
REQ-035 The combinational lane encoder is one sub-module, store_lane_encoder (inputs addr offset, size, data, BIG_ENDIAN; outputs wdata, be, misaligned); the FIFO and merge logic sit in the top module.

Verification (DW=32, BIG_ENDIAN=1 unless stated)
REQ-036 Byte store addr 0x1001, data 0xAB -> mem_addr 0x1000, mem_be 0010, mem_wdata 0x00AB0000, one cycle after acceptance.
REQ-037 Half store addr 0x2000, data 0x1234 -> be 0011, wdata 0x12340000; half store addr 0x2002 -> be 1100, wdata 0x00001234; with BIG_ENDIAN=0, addr 0x2002 -> be 1100, wdata 0x12340000.
REQ-038 Half store addr 0x2001 -> err_valid pulse with err_addr 0x2001, count unchanged, no mem_valid.
REQ-039 mem_ready=0, five back-to-back word stores to distinct addresses -> count=4 and req_ready=0 on the fifth; then mem_ready=1 -> four beats drain in order, one per cycle, and count returns to 0.
REQ-040 mem_ready=0: word to 0x3000, then bytes 0x11 to 0x3004 and 0x22 to 0x3005 -> count=2, second entry be 0011, wdata 0x11220000.
REQ-041 With count=3, assert rst_n=0 for one cycle -> count=0 and mem_valid=0 immediately; a subsequent store appears alone.
